id_ex_stage: RTL and testbench

ID/EX pipeline register for the 5-stage RISC-V core. It applies the forwarding unit's FWA/FWB selects to the ID-stage register-file operands before latching, so the EX stage receives already-resolved operands. It also detects load-use hazards against the instruction in EX, inserts a bubble, and signals IF/ID to hold. It honours external stall and flush from the pipeline control.

---
 rtl/id_ex_stage_if.sv | 50 +++++
 rtl/id_ex_stage.sv | 132 +++++++++++++
 tb/tb_id_ex_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundles the ID-side inputs, the forwarding and pipeline-control
// inputs, and the latched EX-side outputs of the ID/EX pipeline register.
// master = pipeline/ID side that drives the stage, slave = the stage itself.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic [1:0]        fwa;
  logic [1:0]        fwb;
  logic [XLEN-1:0]   ex_fwd_data;
  logic [XLEN-1:0]   mem_fwd_data;
  logic              stall;
  logic              flush;

  logic              load_use_stall;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_op_a;
  logic [XLEN-1:0]   ex_op_b;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_ctrl, fwa, fwb,
           ex_fwd_data, mem_fwd_data, stall, flush,
    input  load_use_stall, ex_valid, ex_pc, ex_imm, ex_op_a, ex_op_b,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_ctrl, fwa, fwb,
           ex_fwd_data, mem_fwd_data, stall, flush,
    output load_use_stall, ex_valid, ex_pc, ex_imm, ex_op_a, ex_op_b,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage RISC-V core.
// Resolves forwarded operands before latching, detects load-use hazards against
// the instruction in EX and inserts a bubble, and honours stall and flush.
// Optional build macro ID_EX_PERF_CNT_EN adds bubble_cnt/stall_cnt counters.
module id_ex_stage #(
  parameter int XLEN        = 32,
  parameter int CTRL_W      = 12,
  parameter int MEMREAD_BIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] stall_cnt
`endif
);

  logic              r_exValid;
  logic [XLEN-1:0]   r_exPc;
  logic [XLEN-1:0]   r_exImm;
  logic [XLEN-1:0]   r_exOpA;
  logic [XLEN-1:0]   r_exOpB;
  logic [4:0]        r_exRs1;
  logic [4:0]        r_exRs2;
  logic [4:0]        r_exRd;
  logic [CTRL_W-1:0] r_exCtrl;

  logic [XLEN-1:0]   w_opANext;
  logic [XLEN-1:0]   w_opBNext;
  logic              w_loadUse;
  logic              w_rdHit;

  // Operand A select: 01 takes the EX result, 11 the MEM result, else the regfile.
  always_comb begin
    w_opANext = bus.id_rs1_data;
    case (bus.fwa)
      2'b01:   w_opANext = bus.ex_fwd_data;
      2'b11:   w_opANext = bus.mem_fwd_data;
      default: w_opANext = bus.id_rs1_data;
    endcase
  end

  // Operand B select, same encoding as A; op B is also the store data.
  always_comb begin
    w_opBNext = bus.id_rs2_data;
    case (bus.fwb)
      2'b01:   w_opBNext = bus.ex_fwd_data;
      2'b11:   w_opBNext = bus.mem_fwd_data;
      default: w_opBNext = bus.id_rs2_data;
    endcase
  end

  // A load in EX whose (non-x0) destination is read by the ID instruction
  // cannot be forwarded in time, so ID must wait one cycle behind a bubble.
  assign w_rdHit   = (r_exRd == bus.id_rs1) | (r_exRd == bus.id_rs2);
  assign w_loadUse = r_exValid & r_exCtrl[MEMREAD_BIT] & (r_exRd != 5'd0) &
                     bus.id_valid & w_rdHit;

  // Pipeline register: flush beats stall beats load-use bubble beats capture;
  // bubbles clear only valid/ctrl/rd so they can never write or forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exValid <= 1'b0;
      r_exPc    <= '0;
      r_exImm   <= '0;
      r_exOpA   <= '0;
      r_exOpB   <= '0;
      r_exRs1   <= '0;
      r_exRs2   <= '0;
      r_exRd    <= '0;
      r_exCtrl  <= '0;
    end else if (bus.flush) begin
      r_exValid <= 1'b0;
      r_exCtrl  <= '0;
      r_exRd    <= '0;
    end else if (bus.stall) begin
      r_exValid <= r_exValid;
    end else if (w_loadUse) begin
      r_exValid <= 1'b0;
      r_exCtrl  <= '0;
      r_exRd    <= '0;
    end else begin
      r_exValid <= bus.id_valid;
      r_exPc    <= bus.id_pc;
      r_exImm   <= bus.id_imm;
      r_exOpA   <= w_opANext;
      r_exOpB   <= w_opBNext;
      r_exRs1   <= bus.id_rs1;
      r_exRs2   <= bus.id_rs2;
      r_exRd    <= bus.id_rd;
      r_exCtrl  <= bus.id_ctrl;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubbleCnt;
  logic [31:0] r_stallCnt;

  // Event counters: bubbles only count when actually inserted, stalls only
  // when not overridden by a flush; both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubbleCnt <= '0;
      r_stallCnt  <= '0;
    end else begin
      if (!bus.flush && !bus.stall && w_loadUse) begin
        r_bubbleCnt <= r_bubbleCnt + 32'd1;
      end
      if (bus.stall && !bus.flush) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
    end
  end

  assign bubble_cnt = r_bubbleCnt;
  assign stall_cnt  = r_stallCnt;
`endif

  assign bus.load_use_stall = w_loadUse;
  assign bus.ex_valid       = r_exValid;
  assign bus.ex_pc          = r_exPc;
  assign bus.ex_imm         = r_exImm;
  assign bus.ex_op_a        = r_exOpA;
  assign bus.ex_op_b        = r_exOpB;
  assign bus.ex_rs1         = r_exRs1;
  assign bus.ex_rs2         = r_exRs2;
  assign bus.ex_rd          = r_exRd;
  assign bus.ex_ctrl        = r_exCtrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector bench for id_ex_stage with a scoreboard.
// Each vector pushes the hand-computed EX state expected after its edge; a
// monitor pops and compares one entry after every rising edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] ctrl;
  } exState_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic [1:0]  fwa;
    logic [1:0]  fwb;
    logic [31:0] exf;
    logic [31:0] memf;
    logic        stall;
    logic        flush;
  } stim_t;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFails;

  exState_t expQ[$];
  string    nameQ[$];

  id_ex_stage_if #(.XLEN(32), .CTRL_W(12)) ifc ();

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubbleCnt;
  logic [31:0] stallCnt;
`endif

  id_ex_stage #(.XLEN(32), .CTRL_W(12), .MEMREAD_BIT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifc.slave)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .bubble_cnt (bubbleCnt),
    .stall_cnt  (stallCnt)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exState_t actual();
    exState_t a;
    a.valid = ifc.ex_valid;
    a.pc    = ifc.ex_pc;
    a.opA   = ifc.ex_op_a;
    a.opB   = ifc.ex_op_b;
    a.imm   = ifc.ex_imm;
    a.rs1   = ifc.ex_rs1;
    a.rs2   = ifc.ex_rs2;
    a.rd    = ifc.ex_rd;
    a.ctrl  = ifc.ex_ctrl;
    return a;
  endfunction

  function automatic exState_t mkExp(logic v, logic [31:0] pc, logic [31:0] a,
                                     logic [31:0] b, logic [31:0] imm, logic [4:0] rs1,
                                     logic [4:0] rs2, logic [4:0] rd, logic [11:0] ctrl);
    exState_t e;
    e.valid = v; e.pc = pc; e.opA = a; e.opB = b; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.ctrl = ctrl;
    return e;
  endfunction

  function automatic stim_t mkStim(logic v, logic [31:0] pc, logic [31:0] rs1d,
                                   logic [31:0] rs2d, logic [31:0] imm, logic [4:0] rs1,
                                   logic [4:0] rs2, logic [4:0] rd, logic [11:0] ctrl,
                                   logic [1:0] fwa, logic [1:0] fwb, logic [31:0] exf,
                                   logic [31:0] memf, logic stall, logic flush);
    stim_t s;
    s.valid = v; s.pc = pc; s.rs1d = rs1d; s.rs2d = rs2d; s.imm = imm;
    s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.ctrl = ctrl; s.fwa = fwa; s.fwb = fwb;
    s.exf = exf; s.memf = memf; s.stall = stall; s.flush = flush;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [155:0] act, input logic [155:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    ifc.id_valid     = s.valid;
    ifc.id_pc        = s.pc;
    ifc.id_rs1_data  = s.rs1d;
    ifc.id_rs2_data  = s.rs2d;
    ifc.id_imm       = s.imm;
    ifc.id_rs1       = s.rs1;
    ifc.id_rs2       = s.rs2;
    ifc.id_rd        = s.rd;
    ifc.id_ctrl      = s.ctrl;
    ifc.fwa          = s.fwa;
    ifc.fwb          = s.fwb;
    ifc.ex_fwd_data  = s.exf;
    ifc.mem_fwd_data = s.memf;
    ifc.stall        = s.stall;
    ifc.flush        = s.flush;
  endtask

  // Drive one vector 2 ns after a rising edge, check the combinational
  // hazard output, and queue the EX state expected after the next edge.
  task automatic applyStimulus(input string name, input stim_t s, input logic expLus,
                               input exState_t exp);
    @(posedge clk);
    #2;
    drive(s);
    #1;
    checkOutput({name, " load_use_stall"}, {155'd0, ifc.load_use_stall}, {155'd0, expLus});
    expQ.push_back(exp);
    nameQ.push_back(name);
  endtask

  // Monitor: one scoreboard entry is consumed 1 ns after each rising edge.
  initial begin
    exState_t e;
    string    n;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput({n, " ex_state"}, actual(), e);
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    nChecks = 0;
    nFails  = 0;
    rst_n   = 1'b0;
    drive(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 2'b00, 2'b00, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("reset ex_state", actual(), '0);
    checkOutput("reset load_use_stall", {155'd0, ifc.load_use_stall}, 156'd0);

    // Forwarding: fwa=01 -> EX result, fwb=11 -> MEM result.
    applyStimulus("fwd_ex_mem",
      mkStim(1, 32'h100, 32'h11, 32'h44, 32'h8, 5'd1, 5'd2, 5'd3, 12'h001, 2'b01, 2'b11, 32'h22, 32'h33, 0, 0),
      1'b0, mkExp(1, 32'h100, 32'h22, 32'h33, 32'h8, 5'd1, 5'd2, 5'd3, 12'h001));
    // fwa=10 selects the regfile, fwb=00 as well.
    applyStimulus("fwd_regfile",
      mkStim(1, 32'h104, 32'h11, 32'h44, 32'h8, 5'd1, 5'd2, 5'd3, 12'h001, 2'b10, 2'b00, 32'h22, 32'h33, 0, 0),
      1'b0, mkExp(1, 32'h104, 32'h11, 32'h44, 32'h8, 5'd1, 5'd2, 5'd3, 12'h001));
    // lw x5 enters EX.
    applyStimulus("lw_x5",
      mkStim(1, 32'h108, 32'h1000, 32'h55, 32'h10, 5'd2, 5'd0, 5'd5, 12'h003, 2'b00, 2'b00, 32'h0, 32'h0, 0, 0),
      1'b0, mkExp(1, 32'h108, 32'h1000, 32'h55, 32'h10, 5'd2, 5'd0, 5'd5, 12'h003));
    // Dependent on x5 through rs2: bubble, data fields keep the load's values.
    applyStimulus("load_use_bubble",
      mkStim(1, 32'h10C, 32'h66, 32'h77, 32'h0, 5'd6, 5'd5, 5'd7, 12'h001, 2'b00, 2'b00, 32'h0, 32'h0, 0, 0),
      1'b1, mkExp(0, 32'h108, 32'h1000, 32'h55, 32'h10, 5'd2, 5'd0, 5'd0, 12'h000));
    // Held instruction resolves from MEM.
    applyStimulus("load_use_resolve",
      mkStim(1, 32'h10C, 32'h66, 32'h77, 32'h0, 5'd6, 5'd5, 5'd7, 12'h001, 2'b00, 2'b11, 32'h0, 32'hABCD, 0, 0),
      1'b0, mkExp(1, 32'h10C, 32'h66, 32'hABCD, 32'h0, 5'd6, 5'd5, 5'd7, 12'h001));
    // lw x0 enters EX.
    applyStimulus("lw_x0",
      mkStim(1, 32'h110, 32'h1, 32'h2, 32'h4, 5'd1, 5'd2, 5'd0, 12'h003, 2'b00, 2'b00, 32'h0, 32'h0, 0, 0),
      1'b0, mkExp(1, 32'h110, 32'h1, 32'h2, 32'h4, 5'd1, 5'd2, 5'd0, 12'h003));
    // Reader of x0 must not stall.
    applyStimulus("x0_no_stall",
      mkStim(1, 32'h114, 32'h9, 32'hA, 32'h0, 5'd0, 5'd3, 5'd8, 12'h001, 2'b00, 2'b00, 32'h0, 32'h0, 0, 0),
      1'b0, mkExp(1, 32'h114, 32'h9, 32'hA, 32'h0, 5'd0, 5'd3, 5'd8, 12'h001));
    // Second load-use, this time through rs1.
    applyStimulus("lw_x9",
      mkStim(1, 32'h118, 32'h20, 32'h21, 32'hC, 5'd1, 5'd0, 5'd9, 12'h003, 2'b00, 2'b00, 32'h0, 32'h0, 0, 0),
      1'b0, mkExp(1, 32'h118, 32'h20, 32'h21, 32'hC, 5'd1, 5'd0, 5'd9, 12'h003));
    applyStimulus("load_use_bubble2",
      mkStim(1, 32'h11C, 32'h30, 32'h31, 32'h0, 5'd9, 5'd0, 5'd10, 12'h001, 2'b00, 2'b00, 32'h0, 32'h0, 0, 0),
      1'b1, mkExp(0, 32'h118, 32'h20, 32'h21, 32'hC, 5'd1, 5'd0, 5'd0, 12'h000));
    applyStimulus("load_use_resolve2",
      mkStim(1, 32'h11C, 32'h30, 32'h31, 32'h0, 5'd9, 5'd0, 5'd10, 12'h001, 2'b11, 2'b00, 32'h0, 32'h500, 0, 0),
      1'b0, mkExp(1, 32'h11C, 32'h500, 32'h31, 32'h0, 5'd9, 5'd0, 5'd10, 12'h001));
    // Three stall cycles with changing ID and forwarding data: EX holds.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus($sformatf("stall_%0d", i),
        mkStim(1, 32'h200, 32'hDEAD, 32'hBEEF, 32'hF, 5'd1, 5'd2, 5'd3, 12'h001, 2'b01, 2'b11, i, 32'h70 + i, 1, 0),
        1'b0, mkExp(1, 32'h11C, 32'h500, 32'h31, 32'h0, 5'd9, 5'd0, 5'd10, 12'h001));
    end
    // Flush wins over stall.
    applyStimulus("stall_and_flush",
      mkStim(1, 32'h200, 32'hDEAD, 32'hBEEF, 32'hF, 5'd1, 5'd2, 5'd3, 12'h001, 2'b01, 2'b11, 32'h4, 32'h74, 1, 1),
      1'b0, mkExp(0, 32'h11C, 32'h500, 32'h31, 32'h0, 5'd9, 5'd0, 5'd0, 12'h000));
    // Stall while a load-use hazard is visible: hazard reported, EX holds.
    applyStimulus("lw_x4",
      mkStim(1, 32'h120, 32'h40, 32'h41, 32'h0, 5'd1, 5'd2, 5'd4, 12'h003, 2'b00, 2'b00, 32'h0, 32'h0, 0, 0),
      1'b0, mkExp(1, 32'h120, 32'h40, 32'h41, 32'h0, 5'd1, 5'd2, 5'd4, 12'h003));
    applyStimulus("stall_over_load_use",
      mkStim(1, 32'h124, 32'h50, 32'h51, 32'h0, 5'd4, 5'd0, 5'd11, 12'h001, 2'b00, 2'b00, 32'h0, 32'h0, 1, 0),
      1'b1, mkExp(1, 32'h120, 32'h40, 32'h41, 32'h0, 5'd1, 5'd2, 5'd4, 12'h003));
    applyStimulus("load_use_bubble3",
      mkStim(1, 32'h124, 32'h50, 32'h51, 32'h0, 5'd4, 5'd0, 5'd11, 12'h001, 2'b00, 2'b00, 32'h0, 32'h0, 0, 0),
      1'b1, mkExp(0, 32'h120, 32'h40, 32'h41, 32'h0, 5'd1, 5'd2, 5'd0, 12'h000));
    // Resolved instruction is itself a load (lw x12).
    applyStimulus("lw_x12",
      mkStim(1, 32'h128, 32'h50, 32'h51, 32'h0, 5'd4, 5'd0, 5'd12, 12'h003, 2'b11, 2'b00, 32'h0, 32'h600, 0, 0),
      1'b0, mkExp(1, 32'h128, 32'h600, 32'h51, 32'h0, 5'd4, 5'd0, 5'd12, 12'h003));

    // Let the monitor consume the last entry.
    @(posedge clk);
    #2;
`ifdef ID_EX_PERF_CNT_EN
    checkOutput("bubble_cnt", {124'd0, bubbleCnt}, 156'd3);
    checkOutput("stall_cnt", {124'd0, stallCnt}, 156'd4);
`endif
    // Present a reader of x12 so a hazard is pending, then reset mid-cycle.
    ifc.id_valid = 1'b1;
    ifc.id_rs1   = 5'd12;
    ifc.stall    = 1'b0;
    #1;
    checkOutput("pre_reset load_use_stall", {155'd0, ifc.load_use_stall}, 156'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset ex_state", actual(), '0);
    checkOutput("async_reset load_use_stall", {155'd0, ifc.load_use_stall}, 156'd0);
`ifdef ID_EX_PERF_CNT_EN
    checkOutput("async_reset counters", {92'd0, bubbleCnt, stallCnt}, 156'd0);
`endif
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
